// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle between the core's operand stage and alu_seq.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [4:0]       OP;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] C;
  logic             out_err;

  modport master (
    output in_valid, A, B, OP, out_ready,
    input  in_ready, out_valid, C, out_err
  );

  modport slave (
    input  in_valid, A, B, OP, out_ready,
    output in_ready, out_valid, C, out_err
  );
endinterface

// File: rtl/alu_seq.sv
// Registered handshaked ALU: 1-cycle ops, WIDTH+1-cycle iterative mul/div, result held until taken.
// Define ALU_SEQ_MULDIV_EN to build OP 17-20; otherwise they report out_err like undefined opcodes.
module alu_seq #(
  parameter int WIDTH     = 32,
  parameter int LUI_SHIFT = 12
) (
  input logic      clk,
  input logic      rstn,
  alu_seq_if.slave bus
);
  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic             rdy_q;
  logic             in_rdy;
  logic             accept;
  logic             long_op;
  logic             last_iter;
  logic [WIDTH-1:0] c_q, c_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] alu_res;
  logic             alu_err;
  logic [WIDTH-1:0] md_res;
  logic [SW-1:0]    sh;

  assign accept = bus.in_valid && in_rdy;

  always_comb begin
    sh      = bus.B[SW-1:0];
    alu_res = '0;
    alu_err = 1'b0;
    case (bus.OP)
      5'd0:        alu_res = bus.A + bus.B;
      5'd1:        alu_res = bus.A - bus.B;
      5'd2:        alu_res = bus.A & bus.B;
      5'd3:        alu_res = bus.A | bus.B;
      5'd4, 5'd11: alu_res = {{(WIDTH-1){1'b0}}, bus.A < bus.B};
      5'd5:        alu_res = bus.A << sh;
      5'd6:        alu_res = bus.A ^ bus.B;
      5'd7:        alu_res = $signed(bus.A) >>> sh;
      5'd8:        alu_res = '0;
      5'd9:        alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.A) >= $signed(bus.B)};
      5'd10:       alu_res = bus.A >> sh;
      5'd12:       alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.A) < $signed(bus.B)};
      5'd13:       alu_res = bus.A << LUI_SHIFT;
      5'd14:       alu_res = {{(WIDTH-1){1'b0}}, bus.A != bus.B};
      5'd15:       alu_res = {{(WIDTH-1){1'b0}}, bus.A >= bus.B};
      5'd16:       alu_res = {{(WIDTH-1){1'b0}}, bus.A == bus.B};
      default:     alu_err = 1'b1;
    endcase
  end

`ifdef ALU_SEQ_MULDIV_EN
  logic [WIDTH-1:0] hi_q, lo_q, b_q, hi_d, lo_d;
  logic [4:0]       op_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   sum, trial;
  logic             is_div;

  assign long_op   = (bus.OP >= 5'd17) && (bus.OP <= 5'd20);
  assign last_iter = (cnt_q == CW'(1));

  // hi/lo hold {product} for mul and {remainder, shifting dividend/quotient} for div
  always_comb begin
    is_div = (op_q == 5'd19) || (op_q == 5'd20);
    sum    = {1'b0, hi_q} + {1'b0, b_q};
    trial  = {hi_q, lo_q[WIDTH-1]} - {1'b0, b_q};
    if (is_div) begin
      if (!trial[WIDTH]) begin
        hi_d = trial[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_d = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else if (lo_q[0]) begin
      hi_d = sum[WIDTH:1];
      lo_d = {sum[0], lo_q[WIDTH-1:1]};
    end else begin
      hi_d = {1'b0, hi_q[WIDTH-1:1]};
      lo_d = {hi_q[0], lo_q[WIDTH-1:1]};
    end
    md_res = ((op_q == 5'd17) || (op_q == 5'd19)) ? lo_d : hi_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      op_q  <= '0;
      cnt_q <= '0;
    end else if (accept && long_op) begin
      hi_q  <= '0;
      lo_q  <= bus.A;
      b_q   <= bus.B;
      op_q  <= bus.OP;
      cnt_q <= CW'(WIDTH);
    end else if (state_q == BUSY) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q - CW'(1);
    end
  end
`else
  assign long_op   = 1'b0;
  assign last_iter = 1'b0;
  assign md_res    = '0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = long_op ? BUSY : DONE;
      BUSY: if (last_iter) state_d = DONE;
      DONE: if (bus.out_ready) state_d = accept ? (long_op ? BUSY : DONE) : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_rdy        = rdy_q && ((state_q == IDLE) || ((state_q == DONE) && bus.out_ready));
    bus.out_valid = (state_q == DONE);
  end

  always_comb begin
    c_d   = c_q;
    err_d = err_q;
    if (accept && !long_op) begin
      c_d   = alu_res;
      err_d = alu_err;
    end else if ((state_q == BUSY) && last_iter) begin
      c_d   = md_res;
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      c_q   <= '0;
      err_q <= 1'b0;
    end else begin
      c_q   <= c_d;
      err_q <= err_d;
    end
  end

  assign bus.in_ready = in_rdy;
  assign bus.C        = c_q;
  assign bus.out_err  = err_q;
endmodule

// File: tb/tb_alu_seq.sv
// Randomised and directed checks of alu_seq against an arithmetic reference model.
module tb_alu_seq;
  localparam int W = 32;

  logic clk;
  logic rstn;
  int   n_tests;
  int   n_fail;

  alu_seq_if #(.WIDTH(W)) bus_if ();

  alu_seq #(.WIDTH(W), .LUI_SHIFT(12)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit is_long(input logic [4:0] op);
`ifdef ALU_SEQ_MULDIV_EN
    return (op >= 5'd17) && (op <= 5'd20);
`else
    return 1'b0;
`endif
  endfunction

  function automatic void model(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] c, output logic e);
    logic [63:0] p;
    int          sh;
    sh = int'(b[4:0]);
    p  = {32'd0, a} * {32'd0, b};
    c  = '0;
    e  = 1'b0;
    case (op)
      5'd0:  c = a + b;
      5'd1:  c = a - b;
      5'd2:  c = a & b;
      5'd3:  c = a | b;
      5'd4, 5'd11: c = (a < b) ? 1 : 0;
      5'd5:  c = a << sh;
      5'd6:  c = a ^ b;
      5'd7:  c = $signed(a) >>> sh;
      5'd8:  c = 0;
      5'd9:  c = ($signed(a) >= $signed(b)) ? 1 : 0;
      5'd10: c = a >> sh;
      5'd12: c = ($signed(a) < $signed(b)) ? 1 : 0;
      5'd13: c = a << 12;
      5'd14: c = (a != b) ? 1 : 0;
      5'd15: c = (a >= b) ? 1 : 0;
      5'd16: c = (a == b) ? 1 : 0;
`ifdef ALU_SEQ_MULDIV_EN
      5'd17: c = p[31:0];
      5'd18: c = p[63:32];
      5'd19: c = (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd20: c = (b == 0) ? a : a % b;
`endif
      default: e = 1'b1;
    endcase
  endfunction

  // Issue one op from IDLE with out_ready=1, report result, error, latency and whether in_ready rose while waiting.
  task automatic do_op(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] c, output logic e, output int lat, output bit rdy_seen);
    bus_if.OP        = op;
    bus_if.A         = a;
    bus_if.B         = b;
    bus_if.in_valid  = 1'b1;
    bus_if.out_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    bus_if.A        = $urandom;
    bus_if.B        = $urandom;
    lat      = 1;
    rdy_seen = 1'b0;
    while (!bus_if.out_valid && lat < 200) begin
      if (bus_if.in_ready) rdy_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    c = bus_if.C;
    e = bus_if.out_err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rstn             = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b0;
    bus_if.A         = '0;
    bus_if.B         = '0;
    bus_if.OP        = '0;
    #12;
    n_tests++;
    if (bus_if.C !== '0 || bus_if.out_valid !== 1'b0 || bus_if.out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: C=%h out_valid=%b out_err=%b, required 0/0/0", bus_if.C, bus_if.out_valid, bus_if.out_err);
    end
    n_tests++;
    if (bus_if.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b, required 0", bus_if.in_ready);
    end
    rstn = 1'b1;
    #1;
    n_tests++;
    if (bus_if.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL release_in_ready: got %b before first clk, required 0", bus_if.in_ready);
    end
    @(posedge clk); #1;
    n_tests++;
    if (bus_if.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL first_clk_in_ready: got %b, required 1", bus_if.in_ready);
    end
  endtask

  task automatic test_directed();
    logic [4:0]   ops [8];
    logic [W-1:0] as  [8];
    logic [W-1:0] bs  [8];
    logic [W-1:0] ec  [8];
    logic         ee  [8];
    logic [W-1:0] c;
    logic         e;
    int           lat;
    bit           rdy_seen;
    ops = '{5'd7, 5'd12, 5'd17, 5'd18, 5'd19, 5'd20, 5'd25, 5'd13};
    as  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100, 32'd100, 32'h1234, 32'h000A_BCDE};
    bs  = '{32'd4, 32'd0, 32'd2, 32'd2, 32'd0, 32'd7, 32'd9, 32'd0};
`ifdef ALU_SEQ_MULDIV_EN
    ec  = '{32'hF800_0000, 32'd1, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'hABCD_E000};
    ee  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`else
    ec  = '{32'hF800_0000, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'hABCD_E000};
    ee  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`endif
    for (int i = 0; i < 8; i++) begin
      do_op(ops[i], as[i], bs[i], c, e, lat, rdy_seen);
      n_tests++;
      if (c !== ec[i] || e !== ee[i]) begin
        n_fail++;
        $display("FAIL directed_op%0d: C=%h err=%b, required C=%h err=%b", ops[i], c, e, ec[i], ee[i]);
      end
      n_tests++;
      if (lat != (is_long(ops[i]) ? W + 1 : 1) || rdy_seen) begin
        n_fail++;
        $display("FAIL directed_lat_op%0d: latency=%0d in_ready_seen=%b, required %0d/0",
                 ops[i], lat, rdy_seen, is_long(ops[i]) ? W + 1 : 1);
      end
    end
  endtask

  task automatic test_random();
    logic [4:0]   op;
    logic [W-1:0] a, b, c, ec;
    logic         e, ee;
    int           lat;
    bit           rdy_seen;
    for (int i = 0; i < 150; i++) begin
      op = 5'($urandom_range(0, 31));
      a  = $urandom;
      b  = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
      model(op, a, b, ec, ee);
      do_op(op, a, b, c, e, lat, rdy_seen);
      n_tests++;
      if (c !== ec || e !== ee || lat != (is_long(op) ? W + 1 : 1) || rdy_seen) begin
        n_fail++;
        $display("FAIL random_op%0d a=%h b=%h: C=%h err=%b lat=%0d rdy=%b, required C=%h err=%b lat=%0d rdy=0",
                 op, a, b, c, e, lat, rdy_seen, ec, ee, is_long(op) ? W + 1 : 1);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] ax, bx, ay, by, ecx, ecy;
    logic [4:0]   opx;
    logic         eex, eey;
    opx = 5'($urandom_range(0, 16));
    ax  = $urandom;
    bx  = $urandom;
    ay  = $urandom;
    by  = $urandom;
    model(opx, ax, bx, ecx, eex);
    model(5'd1, ay, by, ecy, eey);
    bus_if.OP        = opx;
    bus_if.A         = ax;
    bus_if.B         = bx;
    bus_if.in_valid  = 1'b1;
    bus_if.out_ready = 1'b0;
    @(posedge clk); #1;
    bus_if.OP = 5'd1;
    bus_if.A  = ay;
    bus_if.B  = by;
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (bus_if.out_valid !== 1'b1 || bus_if.C !== ecx || bus_if.out_err !== eex || bus_if.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_cycle%0d: valid=%b C=%h err=%b in_ready=%b, required 1/%h/%b/0",
                 i, bus_if.out_valid, bus_if.C, bus_if.out_err, bus_if.in_ready, ecx, eex);
      end
      @(posedge clk); #1;
    end
    bus_if.out_ready = 1'b1;
    #1;
    n_tests++;
    if (bus_if.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL release_in_ready: got %b, required 1", bus_if.in_ready);
    end
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    n_tests++;
    if (bus_if.out_valid !== 1'b1 || bus_if.C !== ecy || bus_if.out_err !== eey) begin
      n_fail++;
      $display("FAIL back_to_back: valid=%b C=%h err=%b, required 1/%h/%b", bus_if.out_valid, bus_if.C, bus_if.out_err, ecy, eey);
    end
    @(posedge clk); #1;
    n_tests++;
    if (bus_if.out_valid !== 1'b0 || bus_if.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL return_idle: valid=%b in_ready=%b, required 0/1", bus_if.out_valid, bus_if.in_ready);
    end
  endtask

  task automatic test_reset_busy();
    bit stale;
    bus_if.OP        = 5'd19;
    bus_if.A         = 32'd100;
    bus_if.B         = 32'd7;
    bus_if.in_valid  = 1'b1;
    bus_if.out_ready = 1'b0;
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (bus_if.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL inflight_in_ready: got %b, required 0", bus_if.in_ready);
    end
    rstn = 1'b0;
    #1;
    n_tests++;
    if (bus_if.C !== '0 || bus_if.out_valid !== 1'b0 || bus_if.out_err !== 1'b0 || bus_if.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_reset: C=%h valid=%b err=%b in_ready=%b, required 0/0/0/0",
               bus_if.C, bus_if.out_valid, bus_if.out_err, bus_if.in_ready);
    end
    @(posedge clk); #1;
    rstn             = 1'b1;
    bus_if.out_ready = 1'b1;
    stale            = 1'b0;
    repeat (W + 8) begin
      @(posedge clk); #1;
      if (bus_if.out_valid) stale = 1'b1;
    end
    n_tests++;
    if (stale || bus_if.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset: stale_result=%b in_ready=%b, required 0/1", stale, bus_if.in_ready);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_busy();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
